// File: rtl/fifo_sync_flags_if.sv
// Handshake bundle for fifo_sync_flags: the master side is the producer/consumer logic,
// the slave side is the FIFO itself.
interface fifo_sync_flags_if #(
  parameter int MEMORY_WIDTH = 8,
  parameter int MEMORY_DEPTH = 8
);
  localparam int CNT_W = $clog2(MEMORY_DEPTH) + 1;

  logic                    wrEn;
  logic [MEMORY_WIDTH-1:0] inData;
  logic                    rdEn;
  logic                    clrErr;
  logic [MEMORY_WIDTH-1:0] outData;
  logic                    outValid;
  logic                    full;
  logic                    empty;
  logic                    almostFull;
  logic                    almostEmpty;
  logic [CNT_W-1:0]        count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output wrEn, inData, rdEn, clrErr,
    input  outData, outValid, full, empty, almostFull, almostEmpty,
           count, overflow, underflow
  );

  modport slave (
    input  wrEn, inData, rdEn, clrErr,
    output outData, outValid, full, empty, almostFull, almostEmpty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module fifo_sync_flags #(
  parameter int MEMORY_WIDTH     = 8,
  parameter int MEMORY_DEPTH     = 8,
  parameter int ALMOST_FULL_LVL  = MEMORY_DEPTH - 2,
  parameter int ALMOST_EMPTY_LVL = 2
) (
  input logic             clk,
  input logic             rst,
  fifo_sync_flags_if.slave bus
);
  localparam int PTR_W = $clog2(MEMORY_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count_q;
  logic                    overflow_q;
  logic                    underflow_q;
  logic                    full_w;
  logic                    empty_w;
  logic                    rd_accept;
  logic                    wr_accept;
  logic                    ovf_event;
  logic                    udf_event;

  assign full_w  = (count_q == CNT_W'(MEMORY_DEPTH));
  assign empty_w = (count_q == '0);

  // A write into a full FIFO still goes through when a read frees a slot in the same cycle.
  always_comb begin
    rd_accept = bus.rdEn & ~empty_w;
    wr_accept = bus.wrEn & (~full_w | rd_accept);
    ovf_event = bus.wrEn & full_w & ~rd_accept;
    udf_event = bus.rdEn & empty_w;
  end

  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      mem[wr_ptr] <= bus.inData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Set beats clear when an error coincides with clrErr.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_event) begin
        overflow_q <= 1'b1;
      end else if (bus.clrErr) begin
        overflow_q <= 1'b0;
      end
      if (udf_event) begin
        underflow_q <= 1'b1;
      end else if (bus.clrErr) begin
        underflow_q <= 1'b0;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.outData  = mem[rd_ptr];
  assign bus.outValid = ~empty_w;
`else
  logic [MEMORY_WIDTH-1:0] out_data_q;
  logic                    out_valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rd_accept;
      if (rd_accept) begin
        out_data_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.outData  = out_data_q;
  assign bus.outValid = out_valid_q;
`endif

  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almostFull  = (count_q >= CNT_W'(ALMOST_FULL_LVL));
  assign bus.almostEmpty = (count_q <= CNT_W'(ALMOST_EMPTY_LVL));
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed plus randomized bench for fifo_sync_flags, checked against a queue-based model
// of the FIFO behaviour; follows FIFO_FWFT_EN when it is defined.
module tb_fifo_sync_flags;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_sync_flags_if #(.MEMORY_WIDTH(W), .MEMORY_DEPTH(D)) bus ();

  fifo_sync_flags #(
    .MEMORY_WIDTH    (W),
    .MEMORY_DEPTH    (D),
    .ALMOST_FULL_LVL (AF),
    .ALMOST_EMPTY_LVL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [W-1:0] model_q[$];
  logic         model_ovf;
  logic         model_udf;
  logic         model_valid;
  logic [W-1:0] model_data;
  int           n_cmp  = 0;
  int           n_fail = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // The model works purely on queue occupancy; pop happens before push so a read+write
  // at full keeps the size at the depth.
  task automatic modelUpdate(input logic rst_v, input logic wr, input logic [W-1:0] din,
                             input logic rd, input logic clr);
    bit was_full, was_empty, rd_ok, wr_ok;
    if (!rst_v) begin
      model_q.delete();
      model_ovf   = 1'b0;
      model_udf   = 1'b0;
      model_valid = 1'b0;
      model_data  = '0;
      return;
    end
    was_full  = (model_q.size() == D);
    was_empty = (model_q.size() == 0);
    rd_ok     = rd && !was_empty;
    wr_ok     = wr && (!was_full || rd_ok);
    model_valid = rd_ok;
    if (rd_ok) model_data = model_q.pop_front();
    if (wr_ok) model_q.push_back(din);
    if (wr && !wr_ok) model_ovf = 1'b1;
    else if (clr)     model_ovf = 1'b0;
    if (rd && was_empty) model_udf = 1'b1;
    else if (clr)        model_udf = 1'b0;
  endtask

  task automatic checkAll(input string tag);
    int n;
    n = model_q.size();
    checkOutput({tag, ".count"},       32'(bus.count),       32'(n));
    checkOutput({tag, ".empty"},       32'(bus.empty),       32'(n == 0));
    checkOutput({tag, ".full"},        32'(bus.full),        32'(n == D));
    checkOutput({tag, ".almostFull"},  32'(bus.almostFull),  32'(n >= AF));
    checkOutput({tag, ".almostEmpty"}, 32'(bus.almostEmpty), 32'(n <= AE));
    checkOutput({tag, ".overflow"},    32'(bus.overflow),    32'(model_ovf));
    checkOutput({tag, ".underflow"},   32'(bus.underflow),   32'(model_udf));
`ifdef FIFO_FWFT_EN
    checkOutput({tag, ".outValid"},    32'(bus.outValid),    32'(n != 0));
    if (n != 0) checkOutput({tag, ".outData"}, 32'(bus.outData), 32'(model_q[0]));
`else
    checkOutput({tag, ".outValid"},    32'(bus.outValid),    32'(model_valid));
    checkOutput({tag, ".outData"},     32'(bus.outData),     32'(model_data));
`endif
  endtask

  task automatic applyStimulus(input logic rst_v, input logic wr, input logic [W-1:0] din,
                               input logic rd, input logic clr, input string tag);
    @(negedge clk);
    rst        = rst_v;
    bus.wrEn   = wr;
    bus.inData = din;
    bus.rdEn   = rd;
    bus.clrErr = clr;
    @(posedge clk);
    modelUpdate(rst_v, wr, din, rd, clr);
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [W-1:0] next_data;
    rst        = 1'b0;
    bus.wrEn   = 1'b0;
    bus.inData = '0;
    bus.rdEn   = 1'b0;
    bus.clrErr = 1'b0;
    model_q.delete();
    model_ovf   = 1'b0;
    model_udf   = 1'b0;
    model_valid = 1'b0;
    model_data  = '0;

    $display("[TB] reset with random inputs");
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b0, 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "reset");

    $display("[TB] fill and overflow");
    for (int i = 1; i <= 9; i++)
      applyStimulus(1'b1, 1'b1, W'(i), 1'b0, 1'b0, "fill");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, "clr_ovf");

    $display("[TB] drain order and underflow");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, "drain");
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, "drain_udf");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, "clr_udf");

    $display("[TB] simultaneous read/write at full and empty");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b1, W'(8'h10 + i), 1'b0, 1'b0, "refill");
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, "rw_full");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, "redrain");
    applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, "rw_empty");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, "clr_rw");

    $display("[TB] wrap-around");
    next_data = 8'h40;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, next_data, 1'b0, 1'b0, "wrap_pre");
      next_data++;
    end
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(1'b1, 1'b1, next_data, 1'b0, 1'b0, "wrap_wr");
        next_data++;
      end else begin
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, "wrap_rd");
      end
    end

    $display("[TB] reset mid-stream");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, "pre_mid");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b1, W'(8'hC0 + i), 1'b0, 1'b0, "mid_fill");
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, "mid_rst");
    applyStimulus(1'b1, 1'b1, 8'h5C, 1'b0, 1'b0, "mid_wr");
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, "mid_rd");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, "mid_idle");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 63) != 0), 1'($urandom), W'($urandom),
                    1'($urandom), ($urandom_range(0, 15) == 0), "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
